// File: rtl/rtc_read_sequencer.sv
// Reads the nine RTC time/date/timer registers in order and hands each byte to the
// R0..R8 demux as a dato/selector pair, parking the selector outside 0..8 between writes.
module rtc_read_sequencer #(
   parameter int          TIMEOUT  = 64,
   parameter logic [3:0]  IDLE_SEL = 4'hF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       bus_req,
   output logic [7:0] bus_addr,
   input  logic       bus_ack,
   input  logic [7:0] bus_rdata,
   output logic [7:0] dato,
   output logic [3:0] selector,
   output logic       busy,
   output logic       done,
   output logic       err
);

   // Bus handshake: bus_req is a level held with a stable bus_addr until either a
   // single-cycle bus_ack (bus_rdata valid in that same cycle) or TIMEOUT cycles pass.
   // An ack is only honoured while bus_req is high; ack wins over a same-cycle timeout.

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [3:0] LAST_IDX = 4'd8;

   typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

   state_t          state, state_n;
   logic [3:0]      idx, idx_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic            bus_req_n, busy_n, done_n, err_n;
   logic [7:0]      bus_addr_n, dato_n;
   logic [3:0]      selector_n;

   function automatic logic [7:0] addr_of(input logic [3:0] i);
      case (i)
         4'd0:    addr_of = 8'h21;
         4'd1:    addr_of = 8'h22;
         4'd2:    addr_of = 8'h23;
         4'd3:    addr_of = 8'h24;
         4'd4:    addr_of = 8'h25;
         4'd5:    addr_of = 8'h26;
         4'd6:    addr_of = 8'h41;
         4'd7:    addr_of = 8'h42;
         default: addr_of = 8'h43;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= 4'd0;
         cnt      <= '0;
         bus_req  <= 1'b0;
         bus_addr <= 8'h00;
         dato     <= 8'h00;
         selector <= IDLE_SEL;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         cnt      <= cnt_n;
         bus_req  <= bus_req_n;
         bus_addr <= bus_addr_n;
         dato     <= dato_n;
         selector <= selector_n;
         busy     <= busy_n;
         done     <= done_n;
         err      <= err_n;
      end
   end

   always_comb begin
      state_n    = state;
      idx_n      = idx;
      cnt_n      = cnt;
      bus_req_n  = bus_req;
      bus_addr_n = bus_addr;
      dato_n     = dato;
      selector_n = IDLE_SEL;
      busy_n     = busy;
      done_n     = 1'b0;
      err_n      = err;
      case (state)
         IDLE: begin
            if (start) begin
               idx_n      = 4'd0;
               err_n      = 1'b0;
               busy_n     = 1'b1;
               cnt_n      = '0;
               bus_req_n  = 1'b1;
               bus_addr_n = addr_of(4'd0);
               state_n    = REQ;
            end
         end
         REQ: begin
            if (!bus_req) begin
               // Gap cycle after a timeout: relaunch the request for the next index.
               bus_req_n  = 1'b1;
               bus_addr_n = addr_of(idx);
               cnt_n      = '0;
            end else if (bus_ack) begin
               dato_n     = bus_rdata;
               bus_req_n  = 1'b0;
               cnt_n      = '0;
               selector_n = idx;
               state_n    = WRITE;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               bus_req_n = 1'b0;
               err_n     = 1'b1;
               cnt_n     = '0;
               if (idx == LAST_IDX) begin
                  state_n = DONE;
                  done_n  = 1'b1;
                  busy_n  = 1'b0;
               end else begin
                  idx_n = idx + 4'd1;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         WRITE: begin
            if (idx == LAST_IDX) begin
               state_n = DONE;
               done_n  = 1'b1;
               busy_n  = 1'b0;
            end else begin
               idx_n      = idx + 4'd1;
               bus_req_n  = 1'b1;
               bus_addr_n = addr_of(idx + 4'd1);
               cnt_n      = '0;
               state_n    = REQ;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Scoreboard bench for rtc_read_sequencer: a responder acks each request after a
// per-index delay, expected demux writes and done timing are queued at start.
module tb_rtc_read_sequencer;

   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       bus_ack = 1'b0;
   logic [7:0] bus_rdata = 8'h00;
   logic       bus_req, busy, done, err;
   logic [7:0] bus_addr, dato;
   logic [3:0] selector;

   rtc_read_sequencer #(.TIMEOUT(TO), .IDLE_SEL(4'hF)) dut (
      .clk(clk), .reset(reset), .start(start),
      .bus_req(bus_req), .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .dato(dato), .selector(selector), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [7:0]  addr_tab [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
   int          dly [9];
   logic [7:0]  data [9];
   logic [7:0]  r_dmx [9];
   logic [7:0]  r_exp [9];
   int          wr_cnt [9];

   logic [11:0] exp_q[$];
   int          addr_q[$];
   int          done_cyc_q[$];
   logic        done_err_q[$];

   int   done_cnt = 0;
   int   cur_i = 0;
   int   w = 0;
   logic prev_req = 1'b0;
   logic prev_sel_on = 1'b0;
   logic stray = 1'b0;
   logic resp;
   logic [11:0] e_wr;
   int   e_cyc;
   logic e_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Monitor and responder share one negedge process so ack always follows observation.
   always @(negedge clk) begin
      resp = 1'b0;
      if (selector != 4'hF) begin
         if (prev_sel_on) check("sel_back_to_back", 1, 0);
         if (exp_q.size() == 0) begin
            check("unexpected_write", {selector, dato}, 12'hFFF);
         end else begin
            e_wr = exp_q.pop_front();
            check("write_sel_dato", {selector, dato}, e_wr);
         end
         if (selector <= 4'd8) begin
            r_dmx[selector] = dato;
            wr_cnt[selector]++;
         end
      end
      prev_sel_on = (selector != 4'hF);
      if (done) begin
         done_cnt++;
         if (done_cyc_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e_cyc = done_cyc_q.pop_front();
            e_err = done_err_q.pop_front();
            check("done_cycle", cyc, e_cyc);
            check("done_err", err, e_err);
            check("done_busy", busy, 0);
            for (int i = 0; i < 9; i++) check($sformatf("demux_r%0d", i), r_dmx[i], r_exp[i]);
         end
      end
      if (bus_req) begin
         if (!prev_req) begin
            w = 1;
            if (addr_q.size() == 0) begin
               check("unexpected_req", bus_addr, 0);
            end else begin
               cur_i = addr_q.pop_front();
               check("req_addr", bus_addr, addr_tab[cur_i]);
            end
         end else begin
            w++;
            check("addr_stable", bus_addr, addr_tab[cur_i]);
         end
         check("sel_idle_in_req", selector, 4'hF);
         if (dly[cur_i] >= 0 && w == dly[cur_i] + 1) resp = 1'b1;
      end
      prev_req  = bus_req;
      bus_ack   = resp || stray;
      bus_rdata = stray ? 8'hAA : (resp ? data[cur_i] : 8'h00);
   end

   task automatic start_pass();
      int   sum = 0;
      logic e = 1'b0;
      for (int i = 0; i < 9; i++) begin
         addr_q.push_back(i);
         if (dly[i] >= 0 && dly[i] < TO) begin
            exp_q.push_back({4'(i), data[i]});
            r_exp[i] = data[i];
            sum += dly[i] + 2;
         end else begin
            e = 1'b1;
            sum += (i == 8) ? TO : TO + 1;
         end
      end
      done_cyc_q.push_back(cyc + 1 + sum);
      done_err_q.push_back(e);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", busy, 1);
      check("start_err_clear", err, 0);
   endtask

   task automatic wait_pass();
      int n0 = done_cnt;
      for (int i = 0; i < 2000 && done_cnt == n0; i++) tick();
      if (done_cnt == n0) check("pass_timeout", 0, 1);
      check("writes_drained", exp_q.size(), 0);
   endtask

   task automatic wait_addr(input logic [7:0] a);
      int n = 0;
      while (!(bus_req && bus_addr == a) && n < 500) begin
         tick();
         n++;
      end
      if (n >= 500) check("wait_addr_timeout", 0, 1);
   endtask

   task automatic set_pass(input int d, input logic rnd);
      for (int i = 0; i < 9; i++) begin
         dly[i]  = d;
         data[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(8'h10 + i);
      end
   endtask

   initial begin
      int n;
      logic [7:0] saved [9];
      for (int i = 0; i < 9; i++) begin
         dly[i] = 0; data[i] = 8'h00; r_dmx[i] = 8'h00; r_exp[i] = 8'h00; wr_cnt[i] = 0;
      end
      reset = 1'b1;
      repeat (3) tick();
      check("rst_bus_req", bus_req, 0);
      check("rst_bus_addr", bus_addr, 8'h00);
      check("rst_dato", dato, 8'h00);
      check("rst_selector", selector, 4'hF);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      reset = 1'b0;
      tick();

      // Zero-wait pass with data 10..18.
      set_pass(0, 1'b0);
      start_pass();
      wait_pass();

      // Wait states: three REQ cycles per index.
      set_pass(2, 1'b1);
      start_pass();
      wait_pass();
      for (int i = 0; i < 9; i++) wr_cnt[i] = 0;

      // Timeout on index 4; R4 must keep its prior value.
      set_pass(0, 1'b1);
      for (int i = 0; i < 9; i++) dly[i] = $urandom_range(0, 3);
      dly[4] = -1;
      start_pass();
      wait_pass();
      check("r4_never_written", wr_cnt[4], 0);

      // Timeout on the last index.
      set_pass(1, 1'b1);
      dly[8] = -1;
      start_pass();
      wait_pass();

      // Ack in the same cycle as the timeout boundary counts as success.
      set_pass(0, 1'b1);
      dly[3] = TO - 1;
      dly[5] = TO - 1;
      start_pass();
      wait_pass();

      // start while busy and in the DONE cycle is ignored; next cycle restarts.
      set_pass(0, 1'b1);
      dly[0] = -1;
      start_pass();
      wait_addr(8'h23);
      start = 1'b1; tick(); start = 1'b0;
      wait_addr(8'h43);
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (!done && n < 500) begin tick(); n++; end
      check("done_seen", done, 1);
      set_pass(1, 1'b1);
      start = 1'b1;
      tick();
      start_pass();
      wait_pass();

      // Reset while in WRITE for index 3.
      set_pass(0, 1'b1);
      for (int i = 0; i < 9; i++) begin saved[i] = r_exp[i]; wr_cnt[i] = 0; end
      start_pass();
      n = 0;
      while (selector != 4'd3 && n < 500) begin tick(); n++; end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete(); addr_q.delete(); done_cyc_q.delete(); done_err_q.delete();
      for (int i = 4; i < 9; i++) r_exp[i] = saved[i];
      check("mid_rst_selector", selector, 4'hF);
      check("mid_rst_bus_req", bus_req, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_dato", dato, 8'h00);
      check("r3_written_once", wr_cnt[3], 1);
      stray = 1'b1; tick(); stray = 1'b0; tick();
      check("post_rst_ack_ignored", dato, 8'h00);
      check("post_rst_idle", busy, 0);
      set_pass(0, 1'b1);
      start_pass();
      wait_pass();

      // Stray ack in IDLE must not load data.
      stray = 1'b1; tick(); stray = 1'b0; tick();
      check("idle_ack_dato", dato, data[8]);
      check("idle_ack_busy", busy, 0);
      check("done_queue_empty", done_cyc_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
